// File: rtl/issue_select_pkg.sv
// issue_select_pkg: shared core parameters for the issue/complete stage.
//   RS_ENTRIES  - reservation-station entries
//   NUM_FUS     - functional units (>= 2)
//   FU_W        - FU index width
//   FU_LATENCY  - execution latency of each FU in cycles (each >= 1)
//   LAT_W       - width of the per-FU latency counter
//   fu_state_t  - per-FU lifecycle: IDLE -> EXEC -> WAIT_RET -> IDLE
package issue_select_pkg;

    localparam int RS_ENTRIES = 4;
    localparam int NUM_FUS    = 2;
    localparam int FU_W       = $clog2(NUM_FUS);
    localparam int LAT_W      = 8;

    localparam int FU_LATENCY [NUM_FUS] = '{1, 3};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_RET = 2'd2
    } fu_state_t;

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req       - request vector
//   ptr       - highest-priority index this cycle
//   gnt_idx   - first requester at or after ptr (wrapping)
//   gnt_valid - any request present
module rr_arbiter
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);
    import issue_select_pkg::*;

    localparam int W = $clog2(N);

    // Scan from farthest to nearest so the last hit (nearest to ptr) wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt_idx   = W'((int'(ptr) + i) % N);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// issue_select: picks one ready RS entry per cycle for an idle FU, models the
// FU latency, broadcasts completion and serialises retires one per cycle.
//   clk, rst_n    - clock, async active-low reset
//   reqs          - per-entry ready-to-issue requests
//   entry_fu      - target FU of entry e at [e*FU_W +: FU_W]
//   grant/_valid  - registered grant (one cycle per grant)
//   ready_mask    - bit e*NUM_FUS+f pulses when entry e finishes on FU f
//   retire_entry/_valid - registered retire, one per cycle
//   fu_busy       - FU is not IDLE
module issue_select
#(
    parameter int RS_ENTRIES = issue_select_pkg::RS_ENTRIES,
    parameter int NUM_FUS    = issue_select_pkg::NUM_FUS,
    parameter int FU_W       = $clog2(NUM_FUS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RS_ENTRIES-1:0]         reqs,
    input  logic [RS_ENTRIES*FU_W-1:0]    entry_fu,
    output logic [$clog2(RS_ENTRIES)-1:0] grant,
    output logic                          grant_valid,
    output logic [RS_ENTRIES*NUM_FUS-1:0] ready_mask,
    output logic [$clog2(RS_ENTRIES)-1:0] retire_entry,
    output logic                          retire_valid,
    output logic [NUM_FUS-1:0]            fu_busy
);
    import issue_select_pkg::*;

    localparam int EW = $clog2(RS_ENTRIES);
    localparam int PW = $clog2(NUM_FUS);
    localparam int CW = PW + 1;

    fu_state_t             fu_state [NUM_FUS];
    logic [EW-1:0]         fu_entry [NUM_FUS];
    logic [NUM_FUS-1:0]    fu_grant, fu_done, fu_pop;

    logic [RS_ENTRIES-1:0] elig;
    logic [EW-1:0]         rr_ptr, sel_idx;
    logic                  sel_valid;
    logic [FU_W-1:0]       sel_fu;

    // Retire FIFO: one slot per FU is enough since an FU holds its slot
    // until retired.
    logic [EW-1:0]         q_entry   [NUM_FUS];
    logic [PW-1:0]         q_fu      [NUM_FUS];
    logic [PW-1:0]         push_slot [NUM_FUS];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         q_cnt, n_push;
    logic                  pop;

    logic [RS_ENTRIES*NUM_FUS-1:0] rm_next;

    // An entry qualifies only if its FU index names a real, idle FU; the
    // grant currently on the wire is masked because wakeup drops that
    // request one cycle late.
    always_comb begin
        elig = '0;
        for (int e = 0; e < RS_ENTRIES; e++) begin
            if (reqs[e] && !(grant_valid && int'(grant) == e)) begin
                for (int f = 0; f < NUM_FUS; f++) begin
                    if (int'(entry_fu[e*FU_W +: FU_W]) == f && fu_state[f] == IDLE)
                        elig[e] = 1'b1;
                end
            end
        end
    end

    rr_arbiter #(.N(RS_ENTRIES)) u_arb (
        .req       (elig),
        .ptr       (rr_ptr),
        .gnt_idx   (sel_idx),
        .gnt_valid (sel_valid)
    );

    assign sel_fu = entry_fu[int'(sel_idx)*FU_W +: FU_W];
    assign pop    = (q_cnt != '0);

    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            fu_grant[f] = sel_valid && (int'(sel_fu) == f);
            fu_pop[f]   = pop && (int'(q_fu[rd_ptr]) == f);
        end
    end

    // Same-cycle completions land in consecutive slots, lowest FU first.
    always_comb begin
        int k;
        k = 0;
        for (int f = 0; f < NUM_FUS; f++) begin
            push_slot[f] = PW'((int'(wr_ptr) + k) % NUM_FUS);
            if (fu_done[f]) k++;
        end
        n_push = CW'(k);
    end

    always_comb begin
        rm_next = '0;
        for (int f = 0; f < NUM_FUS; f++)
            if (fu_done[f]) rm_next[int'(fu_entry[f])*NUM_FUS + f] = 1'b1;
    end

    for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu
        fu_state_t        st;
        logic [LAT_W-1:0] cnt;
        logic [EW-1:0]    ent;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st  <= IDLE;
                cnt <= '0;
                ent <= '0;
            end else begin
                case (st)
                    IDLE: if (fu_grant[f]) begin
                        st  <= EXEC;
                        cnt <= LAT_W'(FU_LATENCY[f]);
                        ent <= sel_idx;
                    end
                    EXEC: begin
                        if (cnt == LAT_W'(1)) st <= WAIT_RET;
                        else                  cnt <= cnt - LAT_W'(1);
                    end
                    WAIT_RET: if (fu_pop[f]) st <= IDLE;
                    default: st <= IDLE;
                endcase
            end
        end

        assign fu_state[f] = st;
        assign fu_entry[f] = ent;
        assign fu_done[f]  = (st == EXEC) && (cnt == LAT_W'(1));
        assign fu_busy[f]  = (st != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= '0;
            ready_mask  <= '0;
        end else begin
            grant_valid <= sel_valid;
            ready_mask  <= rm_next;
            if (sel_valid) begin
                grant  <= sel_idx;
                rr_ptr <= (int'(sel_idx) == RS_ENTRIES - 1) ? '0 : sel_idx + EW'(1);
            end
        end
    end

    // Items pushed this edge become poppable on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_cnt        <= '0;
            retire_valid <= 1'b0;
            retire_entry <= '0;
            for (int i = 0; i < NUM_FUS; i++) begin
                q_entry[i] <= '0;
                q_fu[i]    <= '0;
            end
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (fu_done[f]) begin
                    q_entry[push_slot[f]] <= fu_entry[f];
                    q_fu[push_slot[f]]    <= PW'(f);
                end
            end
            wr_ptr       <= PW'((int'(wr_ptr) + int'(n_push)) % NUM_FUS);
            q_cnt        <= q_cnt + n_push - CW'(pop);
            retire_valid <= pop;
            if (pop) begin
                retire_entry <= q_entry[rd_ptr];
                rd_ptr       <= (int'(rd_ptr) == NUM_FUS - 1) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_issue_select.sv
module tb_issue_select;
    localparam int RS = 4;
    localparam int NF = 2;
    localparam int LAT [NF] = '{1, 3};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [RS-1:0] reqs = '0;
    logic [RS-1:0] entry_fu = '0;
    logic [1:0]    grant, retire_entry;
    logic          grant_valid, retire_valid;
    logic [RS*NF-1:0] ready_mask;
    logic [NF-1:0] fu_busy;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    issue_select #(.RS_ENTRIES(RS), .NUM_FUS(NF), .FU_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .reqs(reqs), .entry_fu(entry_fu),
        .grant(grant), .grant_valid(grant_valid), .ready_mask(ready_mask),
        .retire_entry(retire_entry), .retire_valid(retire_valid), .fu_busy(fu_busy)
    );

    // Model: each FU is just "owned by entry X, result due at absolute cycle
    // T"; completed results wait in a plain queue and leave one per cycle.
    typedef struct { int e; int f; } rt_t;
    rt_t  retq[$];
    int   cyc;
    bit   m_gv;
    int   m_g, m_rr;
    int   own [NF];
    int   rdy_at [NF];
    bit   e_gv, e_rv;
    int   e_g, e_re;
    logic [RS*NF-1:0] e_rm;
    logic [NF-1:0]    e_busy;

    function void model_reset();
        retq.delete();
        m_gv = 0; m_g = 0; m_rr = 0;
        for (int u = 0; u < NF; u++) begin own[u] = -1; rdy_at[u] = -1; end
        e_gv = 0; e_rv = 0; e_g = 0; e_re = 0; e_rm = '0; e_busy = '0;
    endfunction

    // Advance one clock edge; cyc is the cycle that just ended.
    function void model_step();
        bit  el [RS];
        int  sel;
        rt_t r;
        for (int e = 0; e < RS; e++)
            el[e] = reqs[e] && !(m_gv && m_g == e) && own[entry_fu[e]] < 0;
        sel = -1;
        for (int i = 0; i < RS; i++) begin
            int e;
            e = (m_rr + i) % RS;
            if (sel < 0 && el[e]) sel = e;
        end
        e_rv = 0;
        if (retq.size() > 0) begin
            r = retq.pop_front();
            e_rv = 1; e_re = r.e;
            own[r.f] = -1;
        end
        e_rm = '0;
        for (int u = 0; u < NF; u++) begin
            if (own[u] >= 0 && rdy_at[u] == cyc + 1) begin
                e_rm[own[u]*NF + u] = 1'b1;
                retq.push_back('{own[u], u});
            end
        end
        m_gv = (sel >= 0);
        if (sel >= 0) begin
            m_g = sel;
            own[entry_fu[sel]] = sel;
            rdy_at[entry_fu[sel]] = cyc + 1 + LAT[entry_fu[sel]];
            m_rr = (sel + 1) % RS;
        end
        e_gv = m_gv; e_g = m_g;
        for (int u = 0; u < NF; u++) e_busy[u] = (own[u] >= 0);
        cyc++;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    endtask

    task automatic compare_all();
        chk("grant_valid", int'(grant_valid), int'(e_gv));
        if (e_gv) chk("grant", int'(grant), e_g);
        chk("ready_mask", int'(ready_mask), int'(e_rm));
        chk("retire_valid", int'(retire_valid), int'(e_rv));
        if (e_rv) chk("retire_entry", int'(retire_entry), e_re);
        chk("fu_busy", int'(fu_busy), int'(e_busy));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_grant_valid"}, int'(grant_valid), 0);
        chk({tag, "_ready_mask"}, int'(ready_mask), 0);
        chk({tag, "_retire_entry"}, int'(retire_entry), 0);
        chk({tag, "_retire_valid"}, int'(retire_valid), 0);
        chk({tag, "_fu_busy"}, int'(fu_busy), 0);
    endtask

    // Leaves the bench just after a posedge with rst_n released: cycle 1.
    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        reqs = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (check) check_zero("reset");
        rst_n = 1'b1;
    endtask

    // Drop reset between edges, outputs must clear without a clock.
    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int got[$];
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        logic [RS-1:0] pend;
        cyc = 0;
        model_reset();

        // Single issue
        do_reset(1'b1);
        reqs = 4'b0001; entry_fu = 4'b0000;
        cycle();
        chk("s1_grant_valid", int'(grant_valid), 1);
        chk("s1_grant", int'(grant), 0);
        reqs = 4'b0000;
        cycle();
        chk("s1_no_regrant", int'(grant_valid), 0);
        chk("s1_ready", int'(ready_mask), 1);
        cycle();
        chk("s1_retire_valid", int'(retire_valid), 1);
        chk("s1_retire_entry", int'(retire_entry), 0);

        // FU contention
        do_reset(1'b0);
        reqs = 4'b0011; entry_fu = 4'b0011;
        cycle();
        chk("s2_grant", int'(grant), 0);
        chk("s2_busy", int'(fu_busy), 2);
        reqs = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s2_hold", int'(grant_valid), 0);
            chk("s2_busy_hold", int'(fu_busy), 2);
        end
        chk("s2_ready", int'(ready_mask), 8'b0000_0010);
        cycle();
        chk("s2_retire", int'(retire_valid), 1);
        cycle();
        chk("s2_grant1_valid", int'(grant_valid), 1);
        chk("s2_grant1", int'(grant), 1);
        reqs = '0;
        repeat (6) cycle();

        // Parallel FUs
        do_reset(1'b0);
        reqs = 4'b0011; entry_fu = 4'b0010;
        cycle();
        chk("s3_g0", int'(grant), 0);
        reqs = 4'b0010;
        cycle();
        chk("s3_g1_valid", int'(grant_valid), 1);
        chk("s3_g1", int'(grant), 1);
        chk("s3_ready0", int'(ready_mask), 8'b0000_0001);
        reqs = 4'b0000;
        cycle();
        chk("s3_retire0", int'(retire_valid), 1);
        chk("s3_retire0_e", int'(retire_entry), 0);
        cycle();
        cycle();
        chk("s3_ready3", int'(ready_mask), 8'b0000_1000);
        cycle();
        chk("s3_retire1", int'(retire_valid), 1);
        chk("s3_retire1_e", int'(retire_entry), 1);

        // Same-cycle completion
        do_reset(1'b0);
        reqs = 4'b0010; entry_fu = 4'b0010;
        cycle();
        chk("s4_g1", int'(grant), 1);
        reqs = 4'b0000;
        cycle();
        reqs = 4'b0001;
        cycle();
        chk("s4_g0_valid", int'(grant_valid), 1);
        chk("s4_g0", int'(grant), 0);
        reqs = 4'b0000;
        cycle();
        chk("s4_ready_both", int'(ready_mask), 8'b0000_1001);
        cycle();
        chk("s4_ret_first", int'(retire_entry), 0);
        cycle();
        chk("s4_ret_second_v", int'(retire_valid), 1);
        chk("s4_ret_second", int'(retire_entry), 1);

        // Round-robin fairness: a granted entry drops its request until all
        // four have been served, then everyone asks again.
        do_reset(1'b0);
        entry_fu = 4'b1010;
        pend = 4'b1111;
        reqs = pend;
        for (int i = 0; i < 60 && got.size() < 5; i++) begin
            cycle();
            if (grant_valid) begin
                got.push_back(int'(grant));
                pend[grant] = 1'b0;
                if (pend == '0) pend = 4'b1111;
            end
            reqs = pend;
        end
        chk("s5_grant_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("s5_order", got[i], exp_rr[i]);

        // Reset mid-op while FU1 is executing
        do_reset(1'b0);
        reqs = 4'b0010; entry_fu = 4'b0010;
        cycle();
        chk("s6_grant", int'(grant), 1);
        reqs = 4'b0000;
        cycle();
        chk("s6_fu1_busy", int'(fu_busy), 2);
        async_reset_check();
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("s6_no_ready", int'(ready_mask), 0);
            chk("s6_no_retire", int'(retire_valid), 0);
        end

        // Random traffic against the model
        do_reset(1'b0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) reqs = 4'($urandom);
            else reqs = reqs | 4'($urandom & $urandom);
            entry_fu = 4'($urandom);
            cycle();
            if (grant_valid && $urandom_range(0, 1) == 1) reqs[grant] = 1'b0;
            if ($urandom_range(0, 499) == 0) async_reset_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
